// File: rtl/lcd_pkg.sv
// Shared definitions for the ILI9341 LCD byte-stream path.
// Contents:
//   - ILI9341 opcodes used for a full-frame write (CASET, PASET, RAMWR)
//   - RGB565 colour constants for the bar pattern
//   - FSM state encoding for lcd_frame_stream
//   - helpers: bar index -> colour, address-window argument byte selection
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET_CMD,
    S_CASET_ARG,
    S_PASET_CMD,
    S_PASET_ARG,
    S_RAMWR_CMD,
    S_PIX_HI,
    S_PIX_LO
  } state_t;

  // Classic SMPTE-like bar order, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

  // CASET/PASET arguments: start = 0x0000, end = last, each big-endian.
  function automatic logic [7:0] addr_arg(input logic [1:0] idx, input logic [15:0] last);
    logic [7:0] b;
    case (idx)
      2'd2:    b = last[15:8];
      2'd3:    b = last[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_frame_stream_if.sv
// Byte-word stream between the frame source and the SPI byte engine.
// Signals:
//   data  [8:0]  {dc, byte}; dc=0 command, dc=1 data/pixel
//   valid        data holds a word to send
//   ready        consumer accepts the word (qualified by the byte-clock enable)
// Modports: master (frame source), slave (SPI byte engine).
interface lcd_frame_stream_if;
  logic [8:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lcd_pattern_gen.sv
// Combinational test-pattern generator for RGB565 pixels.
// Ports:
//   x, y     pixel coordinates
//   pattern  0/3 = solid colour, 1 = colour bars, 2 = 8x8 checker (color / ~color)
//   color    base colour for solid and checker patterns
//   pixel    resulting RGB565 pixel
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_RES     = 320,
  parameter int BAR_COUNT = 8,
  parameter int X_W       = 9,
  parameter int Y_W       = 8
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [1:0]     pattern,
  input  logic [15:0]    color,
  output logic [15:0]    pixel
);

  localparam int BAR_W = H_RES / BAR_COUNT;

  logic [2:0] bar_sel;
  logic       chk_bit;

  always_comb begin
    // Bars past the eighth reuse the colour table cyclically.
    bar_sel = 3'((32'(x) / BAR_W) % 8);
    // Bit 3 of each coordinate toggles every 8 pixels.
    chk_bit = 1'((32'(x) >> 3) ^ (32'(y) >> 3));
    case (pattern)
      2'd1:    pixel = bar_color(bar_sel);
      2'd2:    pixel = chk_bit ? ~color : color;
      default: pixel = color;
    endcase
  end

endmodule

// File: rtl/lcd_frame_stream.sv
// Frame source for the ILI9341 SPI byte engine. On frame_start it emits a
// complete frame write as {dc,byte} words: CASET + 4 args, PASET + 4 args,
// RAMWR, then H_RES*V_RES RGB565 pixels (MSB byte first) from lcd_pattern_gen.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           byte-clock enable; all state advances only when high
//   frame_start  frame request, honoured in IDLE with en
//   pattern      pattern select, latched at frame start
//   color        base colour, latched at frame start
//   out          stream master (data/valid/ready)
//   busy         high while a frame is in flight
//   frame_done   one-clock pulse after the final pixel byte is accepted
module lcd_frame_stream
  import lcd_pkg::*;
#(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int BAR_COUNT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      frame_start,
  input  logic [1:0]                pattern,
  input  logic [15:0]               color,
  lcd_frame_stream_if.master        out,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST = 16'(V_RES - 1);

  state_t         state_reg, state_next;
  logic [8:0]     data_reg, data_next;
  logic           valid_reg, valid_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic [1:0]     arg_reg, arg_next;
  logic [1:0]     pat_reg, pat_next;
  logic [15:0]    color_reg, color_next;
  logic [7:0]     pix_lo_reg, pix_lo_next;

  logic           xfer;
  logic           x_last, y_last;
  logic [X_W-1:0] x_adv, gen_x;
  logic [Y_W-1:0] y_adv, gen_y;
  logic [15:0]    gen_pixel;

  assign xfer   = en && valid_reg && out.ready;
  assign x_last = (x_reg == X_W'(H_RES - 1));
  assign y_last = (y_reg == Y_W'(V_RES - 1));
  assign x_adv  = x_last ? '0 : x_reg + 1'b1;
  assign y_adv  = x_last ? (y_last ? '0 : y_reg + 1'b1) : y_reg;

  // While the LO byte is pending, the next HI byte belongs to the following
  // pixel, so the generator looks one pixel ahead to avoid a bubble.
  assign gen_x = (state_reg == S_PIX_LO) ? x_adv : x_reg;
  assign gen_y = (state_reg == S_PIX_LO) ? y_adv : y_reg;

  lcd_pattern_gen #(
    .H_RES     (H_RES),
    .BAR_COUNT (BAR_COUNT),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) u_pattern_gen (
    .x       (gen_x),
    .y       (gen_y),
    .pattern (pat_reg),
    .color   (color_reg),
    .pixel   (gen_pixel)
  );

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    x_next      = x_reg;
    y_next      = y_reg;
    arg_next    = arg_reg;
    pat_next    = pat_reg;
    color_next  = color_reg;
    pix_lo_next = pix_lo_reg;

    case (state_reg)
      S_IDLE: begin
        if (en && frame_start) begin
          pat_next   = pattern;
          color_next = color;
          busy_next  = 1'b1;
          valid_next = 1'b1;
          data_next  = {1'b0, CMD_CASET};
          state_next = S_CASET_CMD;
        end
      end
      S_CASET_CMD: begin
        if (xfer) begin
          arg_next   = 2'd0;
          data_next  = {1'b1, addr_arg(2'd0, H_LAST)};
          state_next = S_CASET_ARG;
        end
      end
      S_CASET_ARG: begin
        if (xfer) begin
          arg_next = arg_reg + 2'd1;
          if (arg_reg == 2'd3) begin
            data_next  = {1'b0, CMD_PASET};
            state_next = S_PASET_CMD;
          end else begin
            data_next = {1'b1, addr_arg(arg_reg + 2'd1, H_LAST)};
          end
        end
      end
      S_PASET_CMD: begin
        if (xfer) begin
          arg_next   = 2'd0;
          data_next  = {1'b1, addr_arg(2'd0, V_LAST)};
          state_next = S_PASET_ARG;
        end
      end
      S_PASET_ARG: begin
        if (xfer) begin
          arg_next = arg_reg + 2'd1;
          if (arg_reg == 2'd3) begin
            data_next  = {1'b0, CMD_RAMWR};
            state_next = S_RAMWR_CMD;
          end else begin
            data_next = {1'b1, addr_arg(arg_reg + 2'd1, V_LAST)};
          end
        end
      end
      S_RAMWR_CMD: begin
        if (xfer) begin
          data_next   = {1'b1, gen_pixel[15:8]};
          pix_lo_next = gen_pixel[7:0];
          state_next  = S_PIX_HI;
        end
      end
      S_PIX_HI: begin
        if (xfer) begin
          data_next  = {1'b1, pix_lo_reg};
          state_next = S_PIX_LO;
        end
      end
      S_PIX_LO: begin
        if (xfer) begin
          x_next = x_adv;
          y_next = y_adv;
          if (x_last && y_last) begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            data_next  = 9'h000;
            state_next = S_IDLE;
          end else begin
            data_next   = {1'b1, gen_pixel[15:8]};
            pix_lo_next = gen_pixel[7:0];
            state_next  = S_PIX_HI;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      data_reg   <= 9'h000;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      arg_reg    <= 2'd0;
      pat_reg    <= 2'd0;
      color_reg  <= 16'h0000;
      pix_lo_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      arg_reg    <= arg_next;
      pat_reg    <= pat_next;
      color_reg  <= color_next;
      pix_lo_reg <= pix_lo_next;
    end
  end

  assign out.data   = data_reg;
  assign out.valid  = valid_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule
